sad_row_feeder: RTL and testbench

Sequencer on the driving side of the vertical SAD processor array. It assembles a ROW_W-bit original-image row from a word stream, serialises a TPL_W-bit template row one bit per clock onto the array's template input, and pulses the row-change control. It then samples the array's match status and coordinate and returns one result record per row through a valid/ready handshake. One frame is ROWS rows, started by a start pulse.

---
 rtl/sad_row_feeder_if.sv | 32 +++
 rtl/sad_row_feeder.sv | 180 ++++++++++++++++++
 tb/tb_sad_row_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_row_feeder_if.sv
// Stream and result handshake bundle between the SAD row feeder and its
// pixel/template producers and its result consumer.
interface sad_row_feeder_if #(
  parameter int WORD_W  = 32,
  parameter int TPL_W   = 40,
  parameter int ROW_CW  = 9,
  parameter int COORD_W = 10
);
  logic               pix_valid;
  logic [WORD_W-1:0]  pix_data;
  logic               pix_ready;
  logic               tpl_valid;
  logic [TPL_W-1:0]   tpl_data;
  logic               tpl_ready;
  logic               res_valid;
  logic               res_ready;
  logic [ROW_CW-1:0]  res_row;
  logic               res_hit;
  logic [COORD_W-1:0] res_coord;

  // Producer/consumer side: drives the streams, consumes results.
  modport master (
    output pix_valid, pix_data, tpl_valid, tpl_data, res_ready,
    input  pix_ready, tpl_ready, res_valid, res_row, res_hit, res_coord
  );

  // Feeder side: accepts the streams, produces result records.
  modport slave (
    input  pix_valid, pix_data, tpl_valid, tpl_data, res_ready,
    output pix_ready, tpl_ready, res_valid, res_row, res_hit, res_coord
  );
endinterface

// File: rtl/sad_row_feeder.sv
// Row sequencer for the vertical SAD array: loads an original row from a word
// stream, shifts the template row out one bit per clock, pulses row-change,
// waits for the array to settle and returns one result record per row.
module sad_row_feeder #(
  parameter int ROW_W      = 640,
  parameter int WORD_W     = 32,
  parameter int TPL_W      = 40,
  parameter int ROWS       = 480,
  parameter int ROW_CW     = 9,
  parameter int COORD_W    = 10,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  sad_row_feeder_if.slave    bus,
  output logic [ROW_W-1:0]   original,
  output logic               template,
  output logic               control_change_row,
  input  logic               sad_status,
  input  logic [COORD_W-1:0] coordinate,
  output logic               busy,
  output logic               done
);

  localparam int NWORDS  = ROW_W / WORD_W;
  localparam int WORD_CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BIT_CW  = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int SET_CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [WORD_CW-1:0] LAST_WORD   = WORD_CW'(NWORDS - 1);
  localparam logic [BIT_CW-1:0]  LAST_BIT    = BIT_CW'(TPL_W - 1);
  localparam logic [SET_CW-1:0]  LAST_SETTLE = SET_CW'(SETTLE_CYC - 1);
  localparam logic [ROW_CW-1:0]  LAST_ROW    = ROW_CW'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_ROW,
    ST_LOAD_TPL,
    ST_STREAM,
    ST_CHANGE,
    ST_SETTLE,
    ST_REPORT
  } state_t;

  state_t                          state_q, state_d;
  logic [ROW_CW-1:0]               row_q, row_d;
  logic [WORD_CW-1:0]              word_q, word_d;
  logic [BIT_CW-1:0]               bit_q, bit_d;
  logic [SET_CW-1:0]               settle_q, settle_d;
  logic [TPL_W-1:0]                tpl_q, tpl_d;
  logic [NWORDS-1:0][WORD_W-1:0]   original_q, original_d;
  logic [ROW_CW-1:0]               res_row_q, res_row_d;
  logic                            res_hit_q, res_hit_d;
  logic [COORD_W-1:0]              res_coord_q, res_coord_d;
  logic                            done_q, done_d;

  // Readies and array-facing strobes decode directly from the state, so they
  // are exclusive by construction and drop to 0 the instant reset asserts.
  assign bus.pix_ready    = (state_q == ST_LOAD_ROW);
  assign bus.tpl_ready    = (state_q == ST_LOAD_TPL);
  assign bus.res_valid    = (state_q == ST_REPORT);
  assign bus.res_row      = res_row_q;
  assign bus.res_hit      = res_hit_q;
  assign bus.res_coord    = res_coord_q;
  assign original         = original_q;
  assign template         = (state_q == ST_STREAM) ? tpl_q[bit_q] : 1'b0;
  assign control_change_row = (state_q == ST_CHANGE);
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;

  // Next-state, counter and datapath-capture logic for the row sequence.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    word_d      = word_q;
    bit_d       = bit_q;
    settle_d    = settle_q;
    tpl_d       = tpl_q;
    original_d  = original_q;
    res_row_d   = res_row_q;
    res_hit_d   = res_hit_q;
    res_coord_d = res_coord_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_ROW;
          row_d   = '0;
          word_d  = '0;
        end
      end
      ST_LOAD_ROW: begin
        if (bus.pix_valid && bus.pix_ready) begin
          original_d[word_q] = bus.pix_data;
          if (word_q == LAST_WORD) begin
            state_d = ST_LOAD_TPL;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      ST_LOAD_TPL: begin
        if (bus.tpl_valid && bus.tpl_ready) begin
          tpl_d   = bus.tpl_data;
          bit_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = ST_CHANGE;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_CHANGE: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The array outputs are only trusted on the final settle cycle.
        if (settle_q == LAST_SETTLE) begin
          res_row_d   = row_q;
          res_hit_d   = sad_status;
          res_coord_d = sad_status ? coordinate : '0;
          state_d     = ST_REPORT;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_REPORT: begin
        if (bus.res_ready) begin
          if (row_q == LAST_ROW) begin
            done_d  = 1'b1;
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            word_d  = '0;
            state_d = ST_LOAD_ROW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, row buffer and result record registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      word_q      <= '0;
      bit_q       <= '0;
      settle_q    <= '0;
      tpl_q       <= '0;
      original_q  <= '0;
      res_row_q   <= '0;
      res_hit_q   <= 1'b0;
      res_coord_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      settle_q    <= settle_d;
      tpl_q       <= tpl_d;
      original_q  <= original_d;
      res_row_q   <= res_row_d;
      res_hit_q   <= res_hit_d;
      res_coord_q <= res_coord_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_sad_row_feeder.sv
// Bench for sad_row_feeder: a phase/timeline model of the row sequence is
// checked against the DUT on every falling edge, with randomized gaps,
// back-pressure and array responses, plus literal checks of key timings.
module tb_sad_row_feeder;
  localparam int ROW_W = 640, WORD_W = 32, TPL_W = 40, ROWS = 3;
  localparam int ROW_CW = 9, COORD_W = 10, SETTLE_CYC = 2;
  localparam int NW = ROW_W / WORD_W;
  typedef logic [ROW_W-1:0] vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [ROW_W-1:0] original;
  logic tmpl, chg, busy, done, sad_status;
  logic [COORD_W-1:0] coordinate;

  sad_row_feeder_if #(.WORD_W(WORD_W), .TPL_W(TPL_W), .ROW_CW(ROW_CW), .COORD_W(COORD_W)) bus ();

  sad_row_feeder #(.ROW_W(ROW_W), .WORD_W(WORD_W), .TPL_W(TPL_W), .ROWS(ROWS), .ROW_CW(ROW_CW),
                   .COORD_W(COORD_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .original(original), .template(tmpl),
    .control_change_row(chg), .sad_status(sad_status), .coordinate(coordinate),
    .busy(busy), .done(done));

  initial forever #5 clk = ~clk;

  int tests = 0, fails = 0, ndone = 0, nw = 0;

  task automatic chk(input string nm, input vec_t got, input vec_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Array response driver: random per cycle, or fixed values for literal rows.
  bit rand_sad = 1'b0, fix_sad = 1'b0;
  logic [COORD_W-1:0] fix_coord = '0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_sad) begin
      sad_status = 1'($urandom_range(0, 1));
      coordinate = COORD_W'($urandom());
    end else begin
      sad_status = fix_sad;
      coordinate = fix_coord;
    end
  end

  // Reference model: phase of the row sequence plus timeline position.
  int mph, mword, mrow, mt;
  logic [NW-1:0][WORD_W-1:0] morig;
  logic [TPL_W-1:0] mtpl;
  logic mdone;
  logic [ROW_CW-1:0] e_row;
  logic e_hit;
  logic [COORD_W-1:0] e_coord;

  task automatic model_reset();
    mph = 0; mword = 0; mrow = 0; mt = 0; morig = '0; mtpl = '0; mdone = 1'b0;
  endtask

  task automatic model_step();
    mdone = 1'b0;
    case (mph)
      0: if (start) begin mph = 1; mword = 0; mrow = 0; end
      1: if (bus.pix_valid) begin
           morig[mword] = bus.pix_data;
           mword++;
           if (mword == NW) mph = 2;
         end
      2: if (bus.tpl_valid) begin mtpl = bus.tpl_data; mt = 0; mph = 3; end
      3: if (mt == TPL_W + SETTLE_CYC) begin
           e_row = ROW_CW'(mrow); e_hit = sad_status;
           e_coord = sad_status ? coordinate : '0;
           mph = 4;
         end else mt++;
      default: if (bus.res_ready) begin
           if (mrow == ROWS - 1) begin mdone = 1'b1; mph = 0; mrow = 0; end
           else begin mrow++; mword = 0; mph = 1; end
         end
    endcase
  endtask

  // Compare process: outputs must match the model on every cycle.
  initial begin
    logic e_t;
    model_reset();
    e_row = '0; e_hit = 1'b0; e_coord = '0;
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      e_t = (mph == 3 && mt < TPL_W) ? mtpl[mt] : 1'b0;
      chk("ctrl{busy,pix_rdy,tpl_rdy,tmpl,chg,res_vld,done}",
          vec_t'({busy, bus.pix_ready, bus.tpl_ready, tmpl, chg, bus.res_valid, done}),
          vec_t'({mph != 0, mph == 1, mph == 2, e_t, (mph == 3 && mt == TPL_W), mph == 4, mdone}));
      chk("original", original, vec_t'(morig));
      if (mph == 4)
        chk("record{row,hit,coord}", vec_t'({bus.res_row, bus.res_hit, bus.res_coord}),
            vec_t'({e_row, e_hit, e_coord}));
      if (done) ndone++;
      if (bus.pix_valid && bus.pix_ready) nw++;
      if (rst) model_step();
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0: return bus.pix_ready;
      1: return bus.tpl_ready;
      default: return bus.res_valid;
    endcase
  endfunction

  // Waits (bounded) until the selected DUT signal is high at a falling edge.
  task automatic wait_sig(input int which, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!sig(which) && n < 300);
    if (!sig(which)) chk({"timeout ", nm}, vec_t'(0), vec_t'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int gap, input bit poke);
    if (poke) pulse_start();
    repeat (gap) begin @(posedge clk); #1; end
    bus.pix_valid = 1'b1; bus.pix_data = w;
    wait_sig(0, "pix_ready");
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic send_tpl(input logic [TPL_W-1:0] t, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    bus.tpl_valid = 1'b1; bus.tpl_data = t;
    wait_sig(1, "tpl_ready");
    @(posedge clk); #1;
    bus.tpl_valid = 1'b0;
  endtask

  task automatic rand_row(input bit poke, input bit allow_early);
    logic [63:0] r;
    logic [TPL_W-1:0] t;
    bit early, pre;
    int d;
    r = {$urandom(), $urandom()};
    t = r[TPL_W-1:0];
    early = allow_early && ($urandom_range(0, 1) == 1);
    pre = ($urandom_range(0, 2) == 0);
    d = $urandom_range(1, 6);
    rand_sad = 1'b1;
    bus.res_ready = pre;
    if (early) begin bus.tpl_valid = 1'b1; bus.tpl_data = t; end
    for (int k = 0; k < NW; k++)
      send_word($urandom(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, poke && k == 5);
    if (early) begin
      wait_sig(1, "tpl_ready"); @(posedge clk); #1; bus.tpl_valid = 1'b0;
    end else send_tpl(t, $urandom_range(0, 3));
    wait_sig(2, "res_valid");
    if (!pre) begin
      repeat (d) begin @(posedge clk); #1; end
      bus.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // Main stimulus sequence.
  initial begin
    logic [43:0] tbits, cbits, vbits;
    vec_t exp0;
    int w0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.tpl_valid = 1'b0; bus.tpl_data = '0;
    bus.res_ready = 1'b0; sad_status = 1'b0; coordinate = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset busy", vec_t'(busy), vec_t'(0));
    chk("reset original", original, vec_t'(0));
    chk("reset res_valid", vec_t'(bus.res_valid), vec_t'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Abort a row in the middle of the template stream.
    pulse_start();
    for (int k = 0; k < NW; k++) send_word($urandom(), 0, 1'b0);
    send_tpl('1, 0);
    repeat (10) @(posedge clk); #1;
    chk("mid-stream template", vec_t'(tmpl), vec_t'(1));
    rst = 1'b0; #1;
    chk("async reset busy", vec_t'(busy), vec_t'(0));
    chk("async reset original", original, vec_t'(0));
    chk("async reset template", vec_t'(tmpl), vec_t'(0));
    chk("async reset res_valid", vec_t'(bus.res_valid), vec_t'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Frame 1, row 0: known words, template 0x5, match at 123, ready preset.
    w0 = nw;
    rand_sad = 1'b0; fix_sad = 1'b1; fix_coord = 10'd123; bus.res_ready = 1'b1;
    pulse_start();
    exp0 = '0;
    for (int k = 0; k < NW; k++) begin
      exp0[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
      send_word(WORD_W'(k + 1), 0, 1'b0);
    end
    bus.tpl_valid = 1'b1; bus.tpl_data = 40'h00_0000_0005;
    wait_sig(1, "tpl_ready");
    @(posedge clk); #1;
    bus.tpl_valid = 1'b0;
    for (int s = 0; s < 44; s++) begin
      @(negedge clk);
      tbits[s] = tmpl; cbits[s] = chg; vbits[s] = bus.res_valid;
      if (s == 0) chk("row0 original", original, exp0);
      if (s == 43) chk("row0 record", vec_t'({bus.res_row, bus.res_hit, bus.res_coord}),
                       vec_t'({9'd0, 1'b1, 10'd123}));
    end
    chk("row0 template sequence", vec_t'(tbits), vec_t'(44'h005));
    chk("row0 change timing", vec_t'(cbits), vec_t'(44'h100_0000_0000));
    chk("row0 valid latency", vec_t'(vbits), vec_t'(44'h800_0000_0000));
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    // Row 1: no match, coordinate must be masked; 10 cycles of back-pressure.
    fix_sad = 1'b0; fix_coord = 10'd77;
    for (int k = 0; k < NW; k++) send_word($urandom(), (k % 4 == 1) ? 2 : 0, 1'b0);
    send_tpl(40'h12_3456_789A, 2);
    wait_sig(2, "res_valid");
    for (int i = 0; i < 10; i++) begin
      chk("backpressure record", vec_t'({bus.res_row, bus.res_hit, bus.res_coord}),
          vec_t'({9'd1, 1'b0, 10'd0}));
      chk("backpressure pix_ready", vec_t'(bus.pix_ready), vec_t'(0));
      @(negedge clk);
    end
    @(posedge clk); #1; bus.res_ready = 1'b1;
    @(posedge clk); #1; bus.res_ready = 1'b0;
    @(negedge clk);
    chk("after accept pix_ready", vec_t'(bus.pix_ready), vec_t'(1));
    chk("after accept res_valid", vec_t'(bus.res_valid), vec_t'(0));
    @(posedge clk); #1;

    // Row 2: random gaps, start pulse while loading, random array responses.
    rand_row(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("frame1 done count", vec_t'(ndone), vec_t'(1));
    chk("frame1 busy after", vec_t'(busy), vec_t'(0));
    chk("frame1 words consumed", vec_t'(nw - w0), vec_t'(ROWS * NW));
    @(posedge clk); #1;

    // Frame 2: fully randomized, template may be offered alongside pixels.
    pulse_start();
    for (int r = 0; r < ROWS; r++) rand_row(1'($urandom_range(0, 1)), 1'b1);
    repeat (3) @(negedge clk);
    chk("frame2 done count", vec_t'(ndone), vec_t'(2));
    chk("frame2 busy after", vec_t'(busy), vec_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global bound on run length.
  initial begin
    repeat (40000) @(posedge clk);
    chk("watchdog", vec_t'(0), vec_t'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
